// File: rtl/mem_test_sequencer.sv
// mem_test_sequencer: writes a seeded pattern to every address of a byte-wide memory, reads it back, compares.
// Optional build macro MEMTEST_INVERT_PASS_EN adds a second write/read pass using the inverted pattern.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | writing pattern(addr), one address per cycle
// READ  | issuing reads; comparing data returned for the previous address
// DRAIN | comparing data returned for the last address
// DONE  | results held until the next accepted start
module mem_test_sequencer #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] seed_q;
  logic              inv_pass;
  logic              start_ok;
  logic              check_en;
  logic              mismatch;
  logic [DATA_W-1:0] wr_pat;
  logic [DATA_W-1:0] exp_pat;
  logic [ERR_W-1:0]  err_next;

  assign start_ok = start && (state == S_IDLE || state == S_DONE);

  assign wr_pat  = (DATA_W'(mem_addr) + seed_q) ^ {DATA_W{inv_pass}};
  assign exp_pat = (DATA_W'(exp_addr) + seed_q) ^ {DATA_W{inv_pass}};

  // First READ cycle has no returned data yet; DRAIN covers the last address.
  assign check_en = (state == S_READ && mem_addr != '0) || state == S_DRAIN;
  assign mismatch = check_en && (mem_rdata != exp_pat);
  assign err_next = (mismatch && !(&err_count)) ? err_count + ERR_W'(1) : err_count;

  assign mem_cs    = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign mem_rw    = (state == S_WRITE);
  assign mem_wdata = (state == S_WRITE) ? wr_pat : '0;

`ifdef MEMTEST_INVERT_PASS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inv_pass <= 1'b0;
    end else if (start_ok) begin
      inv_pass <= 1'b0;
    end else if (state == S_DRAIN) begin
      inv_pass <= 1'b1;
    end
  end
`else
  assign inv_pass = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      mem_addr       <= '0;
      exp_addr       <= '0;
      seed_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      exp_addr <= mem_addr;
      if (check_en) begin
        err_count <= err_next;
        if (mismatch && err_count == '0) first_err_addr <= exp_addr;
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            seed_q         <= seed;
            err_count      <= '0;
            first_err_addr <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            mem_addr       <= '0;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_addr == LAST_ADDR) begin
            mem_addr <= '0;
            state    <= S_READ;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_READ: begin
          if (mem_addr == LAST_ADDR) begin
            state <= S_DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        S_DRAIN: begin
`ifdef MEMTEST_INVERT_PASS_EN
          if (!inv_pass) begin
            mem_addr <= '0;
            state    <= S_WRITE;
          end else
`endif
          begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Bench for mem_test_sequencer: memory model with fault injection plus a cycle-timeline reference model.
module tb_mem_test_sequencer;

  localparam int D = 512;
`ifdef MEMTEST_INVERT_PASS_EN
  localparam int PASSES   = 2;
  localparam int DONE_CYC = 2051;
`else
  localparam int PASSES   = 1;
  localparam int DONE_CYC = 1026;
`endif
  localparam int DONE_K = PASSES * (2 * D + 1) + 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  seed = 8'h00;
  logic [8:0]  mem_addr, first_err_addr, mem_addr4, first_err_addr4;
  logic        mem_cs, mem_rw, busy, done, pass;
  logic        mem_cs4, mem_rw4, busy4, done4, pass4;
  logic [7:0]  mem_wdata, mem_wdata4;
  logic [7:0]  mem_rdata = 8'h00;
  logic [15:0] err_count;
  logic [3:0]  err_count4;

  int checks = 0;
  int failures = 0;
  int fault_mode = 0;

  mem_test_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr)
  );

  // Same stimulus and read data, narrow error counter to exercise saturation.
  mem_test_sequencer #(.ERR_W(4)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .seed(seed),
    .mem_addr(mem_addr4), .mem_cs(mem_cs4), .mem_rw(mem_rw4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata), .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err_count4), .first_err_addr(first_err_addr4)
  );

  always #5 clk = ~clk;

  function automatic bit is_fault(input int mode, input int a);
    return (mode == 2) || (mode == 1 && (a == 7 || a == 300));
  endfunction

  logic [7:0] mem [0:D-1];
  always @(posedge clk) begin
    if (mem_rw) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr] ^ (is_fault(fault_mode, int'(mem_addr)) ? 8'h01 : 8'h00);
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run position k counts cycles since the accepting edge.
  bit         m_run = 0;
  bit         m_done = 0;
  int         k = 0;
  logic [7:0] m_seed = 8'h00;
  int         m_err = 0;
  int         m_first = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_run = 0; m_done = 0; k = 0;
    end else if (m_run) begin
      k++;
      if (k == DONE_K) begin m_run = 0; m_done = 1; end
    end else if (start) begin
      m_run = 1; m_done = 0; k = 1; m_seed = seed; m_err = 0; m_first = 0;
      for (int a = D - 1; a >= 0; a--)
        if (is_fault(fault_mode, a)) begin m_err += PASSES; m_first = a; end
    end
  end

  logic [7:0] wlog  [0:D-1];
  logic [7:0] wlog2 [0:D-1];

  always @(negedge clk) begin
    int p, b, e16, e4;
    logic [7:0] ep;
    check("rw_without_cs", {mem_rw & ~mem_cs, mem_rw4 & ~mem_cs4}, 0);
    if (!reset) begin
      check("reset_ctl", {busy, done, pass, mem_cs, mem_rw, busy4, done4, pass4, mem_cs4, mem_rw4}, 0);
      check("reset_data", {mem_addr, mem_wdata, err_count, first_err_addr}, 0);
      check("reset_data_sat", {mem_addr4, mem_wdata4, err_count4, first_err_addr4}, 0);
    end else if (m_run) begin
      p = (k - 1) / (2 * D + 1);
      b = (k - 1) % (2 * D + 1);
      check("run_status", {busy, done, pass, busy4, done4, pass4}, 6'b100_100);
      if (b < D) begin
        ep = 8'(b + int'(m_seed));
        if (p != 0) ep = ~ep;
        check("write_cyc", {mem_cs, mem_rw, mem_addr, mem_wdata}, {2'b11, 9'(b), ep});
        check("write_cyc_sat", {mem_cs4, mem_rw4, mem_addr4, mem_wdata4}, {2'b11, 9'(b), ep});
        if (p == 0) wlog[b] = mem_wdata; else wlog2[b] = mem_wdata;
      end else if (b < 2 * D) begin
        check("read_cyc", {mem_cs, mem_rw, mem_addr, mem_cs4, mem_rw4, mem_addr4},
              {2'b10, 9'(b - D), 2'b10, 9'(b - D)});
      end else begin
        check("drain_cyc", {mem_cs, mem_rw, mem_cs4, mem_rw4}, 4'b1010);
      end
    end else if (m_done) begin
      e16 = (m_err > 65535) ? 65535 : m_err;
      e4  = (m_err > 15) ? 15 : m_err;
      check("done_status", {busy, done, pass, mem_cs, mem_rw}, {2'b01, m_err == 0, 2'b00});
      check("done_status_sat", {busy4, done4, pass4, mem_cs4, mem_rw4}, {2'b01, m_err == 0, 2'b00});
      check("err_count", err_count, e16);
      check("first_err_addr", first_err_addr, m_first);
      check("err_count_sat", err_count4, e4);
      check("first_err_addr_sat", first_err_addr4, m_first);
    end else begin
      check("idle_outputs", {busy, done, pass, mem_cs, mem_rw, err_count, first_err_addr}, 0);
      check("idle_outputs_sat", {busy4, done4, pass4, mem_cs4, mem_rw4, err_count4, first_err_addr4}, 0);
    end
  end

  task automatic run_test(input logic [7:0] s, input int fm, input int mid, output int cyc);
    fault_mode = fm;
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    cyc   = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      start = (cyc == mid);
      if (done) break;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL done_timeout actual=%0d required=%0d", cyc, DONE_CYC);
    end
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run_test(8'h0A, 0, -1, cyc);
    check("done_cycle_clean", cyc, DONE_CYC);
    check("pass_clean", pass, 1);
    check("err_clean", err_count, 0);
    check("first_clean", first_err_addr, 0);
    check("wdata_addr3", wlog[3], 8'h0D);
    check("wdata_addr255", wlog[255], 8'h09);

    run_test(8'h0A, 1, -1, cyc);
    check("err_two_faults", err_count, 2 * PASSES);
    check("first_two_faults", first_err_addr, 7);
    check("pass_two_faults", pass, 0);

    run_test(8'h0A, 2, -1, cyc);
    check("err_all_faults", err_count, 512 * PASSES);
    check("first_all_faults", first_err_addr, 0);
    check("err_all_faults_sat", err_count4, 15);

    run_test(8'h0A, 0, 100, cyc);
    check("done_cycle_restart_ignored", cyc, DONE_CYC);
    check("pass_restart_ignored", pass, 1);

    fault_mode = 0;
    @(negedge clk);
    seed = 8'h0A;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (599) @(negedge clk);
    check("busy_before_abort", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("abort_ctl", {busy, done, pass, mem_cs, mem_rw}, 0);
    check("abort_counters", {err_count, first_err_addr, mem_addr}, 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_abort", {busy, mem_cs, mem_rw}, 0);

    run_test(8'h5C, 0, -1, cyc);
    check("done_cycle_after_abort", cyc, DONE_CYC);
    check("pass_after_abort", pass, 1);

`ifdef MEMTEST_INVERT_PASS_EN
    run_test(8'h00, 0, -1, cyc);
    check("inv_wdata_addr1", wlog2[1], 8'hFE);
    check("inv_done_cycle", cyc, 2051);
    check("inv_pass", pass, 1);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
